// File: rtl/commit_retire_pkg.sv
// Shared types and constants for the in-order retirement stage.
package commit_retire_pkg;

  localparam int unsigned BUF_SIZE     = 16;
  localparam int unsigned BUF_SIZE_LOG = 4;

  typedef enum logic [1:0] {
    S_NOT_USED     = 2'd0,
    S_NOT_EXECUTED = 2'd1,
    S_EXECUTED     = 2'd2
  } e_state_t;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_MEM = 2'd2,
    UNIT_BR  = 2'd3
  } unit_t;

  typedef enum logic [1:0] {
    RWMM_NONE  = 2'd0,
    RWMM_LOAD  = 2'd1,
    RWMM_STORE = 2'd2
  } rwmm_t;

  typedef enum logic {
    C_IDLE  = 1'b0,
    C_STORE = 1'b1
  } commit_state_t;

  typedef struct packed {
    e_state_t                e_state;
    logic [BUF_SIZE_LOG-1:0] tag;
    logic [5:0]              speculative_tag;
    unit_t                   unit;
    rwmm_t                   rwmm;
    logic [4:0]              dest;
    logic [31:0]             result;
    logic [31:0]             a;
    logic [31:0]             vk;
  } entry_t;

endpackage

// File: rtl/find_entry_by_tag.sv
// Combinational tag CAM: locates the live buffer entry holding each requested tag.
module find_entry_by_tag
  import commit_retire_pkg::*;
(
  input  entry_t                  entries [BUF_SIZE],
  input  logic [BUF_SIZE_LOG-1:0] tag     [2],
  output logic [1:0]              hit,
  output logic [BUF_SIZE_LOG-1:0] index   [2]
);

  for (genvar k = 0; k < 2; k++) begin : g_slot
    logic                    h;
    logic [BUF_SIZE_LOG-1:0] ix;

    // Priority scan from the top so the lowest matching index ends up winning.
    always_comb begin
      h  = 1'b0;
      ix = '0;
      for (int i = BUF_SIZE - 1; i >= 0; i--) begin
        if (entries[i].e_state != S_NOT_USED && entries[i].tag == tag[k]) begin
          h  = 1'b1;
          ix = BUF_SIZE_LOG'(i);
        end
      end
    end

    assign hit[k]   = h;
    assign index[k] = ix;
  end

endmodule

// File: rtl/flopr.sv
// Resettable register with synchronous active-high reset.
module flopr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d each edge, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/commit_retire.sv
// In-order retirement: up to two entries per cycle, stores serialised through a req/ack port.
module commit_retire
  import commit_retire_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  entry_t                  entries_all [BUF_SIZE],
  output logic [1:0]              rf_we,
  output logic [4:0]              rf_addr     [2],
  output logic [31:0]             rf_data     [2],
  output logic [1:0]              free_valid,
  output logic [BUF_SIZE_LOG-1:0] free_index  [2],
  output logic [BUF_SIZE_LOG-1:0] commit_tag,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_data,
  input  logic                    mem_ack
);

  localparam int unsigned TW = BUF_SIZE_LOG;

  commit_state_t state_q, state_d;
  logic [TW-1:0] store_idx_q, store_idx_d;
  logic [TW-1:0] exp_tag [2];
  logic [1:0]    hit;
  logic [TW-1:0] idx [2];
  logic [TW-1:0] commit_tag_d;
  logic          ready0, ready1, store0, store1;

  logic [1:0]    rf_we_d, free_valid_d;
  logic [4:0]    rf_addr_d [2];
  logic [31:0]   rf_data_d [2];
  logic [TW-1:0] free_index_d [2];
  logic          mem_req_d;
  logic [31:0]   mem_addr_d, mem_data_d;

  assign exp_tag[0] = commit_tag - TW'(1);
  assign exp_tag[1] = commit_tag - TW'(2);

  find_entry_by_tag u_find (
    .entries (entries_all),
    .tag     (exp_tag),
    .hit     (hit),
    .index   (idx)
  );

  flopr #(.WIDTH(TW)) u_commit_tag (
    .clk   (clk),
    .reset (reset),
    .d     (commit_tag_d),
    .q     (commit_tag)
  );

  // Retirability of the two oldest entries; slot 1 is only ever considered behind slot 0.
  always_comb begin
    ready0 = hit[0] && entries_all[idx[0]].e_state == S_EXECUTED &&
             entries_all[idx[0]].speculative_tag == 6'b0;
    ready1 = ready0 && hit[1] && entries_all[idx[1]].e_state == S_EXECUTED &&
             entries_all[idx[1]].speculative_tag == 6'b0;
    store0 = entries_all[idx[0]].rwmm == RWMM_STORE;
    store1 = entries_all[idx[1]].rwmm == RWMM_STORE;
  end

  // FSM state and the index of the store in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_IDLE;
      store_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      store_idx_q <= store_idx_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d         = state_q;
    store_idx_d     = store_idx_q;
    commit_tag_d    = commit_tag;
    rf_we_d         = 2'b00;
    free_valid_d    = 2'b00;
    rf_addr_d[0]    = '0;
    rf_addr_d[1]    = '0;
    rf_data_d[0]    = '0;
    rf_data_d[1]    = '0;
    free_index_d[0] = '0;
    free_index_d[1] = '0;
    mem_req_d       = 1'b0;
    mem_addr_d      = '0;
    mem_data_d      = '0;

    case (state_q)
      C_IDLE: begin
        if (ready0 && store0) begin
          state_d     = C_STORE;
          store_idx_d = idx[0];
          mem_req_d   = 1'b1;
          mem_addr_d  = entries_all[idx[0]].a;
          mem_data_d  = entries_all[idx[0]].vk;
        end else if (ready0) begin
          rf_we_d[0]      = entries_all[idx[0]].dest != 5'd0;
          rf_addr_d[0]    = entries_all[idx[0]].dest;
          rf_data_d[0]    = entries_all[idx[0]].result;
          free_valid_d[0] = 1'b1;
          free_index_d[0] = idx[0];
          commit_tag_d    = commit_tag - TW'(1);
          if (ready1 && !store1) begin
            rf_we_d[1]      = entries_all[idx[1]].dest != 5'd0;
            rf_addr_d[1]    = entries_all[idx[1]].dest;
            rf_data_d[1]    = entries_all[idx[1]].result;
            free_valid_d[1] = 1'b1;
            free_index_d[1] = idx[1];
            commit_tag_d    = commit_tag - TW'(2);
            // The younger slot owns the register when both target the same one.
            if (entries_all[idx[0]].dest == entries_all[idx[1]].dest) rf_we_d[0] = 1'b0;
          end
        end
      end
      C_STORE: begin
        if (mem_ack) begin
          state_d         = C_IDLE;
          free_valid_d[0] = 1'b1;
          free_index_d[0] = store_idx_q;
          commit_tag_d    = commit_tag - TW'(1);
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr;
          mem_data_d = mem_data;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we         <= 2'b00;
      free_valid    <= 2'b00;
      rf_addr[0]    <= '0;
      rf_addr[1]    <= '0;
      rf_data[0]    <= '0;
      rf_data[1]    <= '0;
      free_index[0] <= '0;
      free_index[1] <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
    end else begin
      rf_we         <= rf_we_d;
      free_valid    <= free_valid_d;
      rf_addr[0]    <= rf_addr_d[0];
      rf_addr[1]    <= rf_addr_d[1];
      rf_data[0]    <= rf_data_d[0];
      rf_data[1]    <= rf_data_d[1];
      free_index[0] <= free_index_d[0];
      free_index[1] <= free_index_d[1];
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
      mem_data      <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_commit_retire.sv
// Self-checking bench for commit_retire: vector table plus store/reset sequences.
module tb_commit_retire;
  import commit_retire_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  entry_t      entries_all [BUF_SIZE];
  logic [1:0]  rf_we;
  logic [4:0]  rf_addr [2];
  logic [31:0] rf_data [2];
  logic [1:0]  free_valid;
  logic [3:0]  free_index [2];
  logic [3:0]  commit_tag;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;

  commit_retire dut (
    .clk         (clk),
    .reset       (reset),
    .entries_all (entries_all),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .free_valid  (free_valid),
    .free_index  (free_index),
    .commit_tag  (commit_tag),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  we;
    logic [1:0]  fv;
    logic [3:0]  ct;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  fi0, fi1;
    logic        req;
    logic [31:0] ma, md;
  } exp_t;

  typedef struct {
    entry_t a;
    entry_t b;
    exp_t   e;
  } vec_t;

  exp_t sb [$];
  vec_t vq [$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic entry_t ent(logic [3:0] t, e_state_t st, logic [5:0] sp, rwmm_t rw,
                                 logic [4:0] d, logic [31:0] res,
                                 logic [31:0] a = 32'h0, logic [31:0] vk = 32'h0);
    entry_t r;
    r                 = '0;
    r.e_state         = st;
    r.tag             = t;
    r.speculative_tag = sp;
    r.rwmm            = rw;
    r.unit            = (rw == RWMM_NONE) ? UNIT_ALU : UNIT_MEM;
    r.dest            = d;
    r.result          = res;
    r.a               = a;
    r.vk              = vk;
    return r;
  endfunction

  function automatic exp_t ex(string nm, logic [1:0] we, logic [1:0] fv, logic [3:0] ct,
                              logic [4:0] a0, logic [4:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic [3:0] fi0, logic [3:0] fi1, logic req = 1'b0,
                              logic [31:0] ma = 32'h0, logic [31:0] md = 32'h0);
    exp_t r;
    r.nm = nm; r.we = we; r.fv = fv; r.ct = ct;
    r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.fi0 = fi0; r.fi1 = fi1; r.req = req; r.ma = ma; r.md = md;
    return r;
  endfunction

  function automatic exp_t idle(string nm, logic [3:0] ct);
    return ex(nm, 2'b00, 2'b00, ct, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(entry_t a, entry_t b, exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.e = e;
    vq.push_back(v);
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_entries();
    foreach (entries_all[i]) entries_all[i] = '0;
  endtask

  // Push the expectation, advance one edge, then pop and compare against the DUT.
  task automatic step(exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    cmp({x.nm, ".rf_we"}, 32'(rf_we), 32'(x.we));
    cmp({x.nm, ".free_valid"}, 32'(free_valid), 32'(x.fv));
    cmp({x.nm, ".commit_tag"}, 32'(commit_tag), 32'(x.ct));
    cmp({x.nm, ".mem_req"}, 32'(mem_req), 32'(x.req));
    if (x.we[0]) begin
      cmp({x.nm, ".rf_addr0"}, 32'(rf_addr[0]), 32'(x.a0));
      cmp({x.nm, ".rf_data0"}, rf_data[0], x.d0);
    end
    if (x.we[1]) begin
      cmp({x.nm, ".rf_addr1"}, 32'(rf_addr[1]), 32'(x.a1));
      cmp({x.nm, ".rf_data1"}, rf_data[1], x.d1);
    end
    if (x.fv[0]) cmp({x.nm, ".free_index0"}, 32'(free_index[0]), 32'(x.fi0));
    if (x.fv[1]) cmp({x.nm, ".free_index1"}, 32'(free_index[1]), 32'(x.fi1));
    if (x.req) begin
      cmp({x.nm, ".mem_addr"}, mem_addr, x.ma);
      cmp({x.nm, ".mem_data"}, mem_data, x.md);
    end
  endtask

  task automatic do_reset(string nm);
    reset = 1'b1;
    step(ex(nm, 2'b00, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0));
    cmp({nm, ".mem_addr_zero"}, mem_addr, 32'h0);
    cmp({nm, ".rf_addr0_zero"}, 32'(rf_addr[0]), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    reset   = 1'b1;
    mem_ack = 1'b0;
    clear_entries();

    // Entry A sits at index 9, entry B at index 2; commit_tag is tracked by hand.
    add(ent(15, S_EXECUTED, 0, RWMM_LOAD, 3, 32'hA), ent(14, S_EXECUTED, 0, RWMM_NONE, 4, 32'hB),
        ex("pair_t15_t14", 2'b11, 2'b11, 14, 3, 4, 32'hA, 32'hB, 9, 2));
    add(ent(13, S_NOT_EXECUTED, 0, RWMM_NONE, 5, 32'h13), ent(12, S_EXECUTED, 0, RWMM_NONE, 6, 32'h12),
        idle("older_not_exec", 14));
    add(ent(13, S_EXECUTED, 0, RWMM_NONE, 5, 32'h13), ent(12, S_EXECUTED, 0, RWMM_NONE, 6, 32'h12),
        ex("older_now_exec", 2'b11, 2'b11, 12, 5, 6, 32'h13, 32'h12, 9, 2));
    add(ent(11, S_EXECUTED, 6'b000010, RWMM_NONE, 1, 32'h11), ent(10, S_EXECUTED, 0, RWMM_NONE, 2, 32'h10),
        idle("speculative_block", 12));
    add(ent(11, S_EXECUTED, 0, RWMM_NONE, 1, 32'h11), ent(10, S_EXECUTED, 0, RWMM_NONE, 2, 32'h10),
        ex("spec_cleared", 2'b11, 2'b11, 10, 1, 2, 32'h11, 32'h10, 9, 2));
    add(ent(9, S_EXECUTED, 0, RWMM_NONE, 0, 32'h9), ent(8, S_EXECUTED, 0, RWMM_NONE, 7, 32'h8),
        ex("dest_x0", 2'b10, 2'b11, 8, 0, 7, 0, 32'h8, 9, 2));
    add(ent(7, S_EXECUTED, 0, RWMM_NONE, 9, 32'h7), ent(6, S_EXECUTED, 0, RWMM_NONE, 9, 32'h6),
        ex("same_dest", 2'b10, 2'b11, 6, 0, 9, 0, 32'h6, 9, 2));
    add(ent(5, S_EXECUTED, 0, RWMM_NONE, 10, 32'h5), ent(4, S_NOT_USED, 0, RWMM_NONE, 11, 32'h4),
        ex("single_retire", 2'b01, 2'b01, 5, 10, 0, 32'h5, 0, 9, 0));
    add(ent(3, S_EXECUTED, 0, RWMM_NONE, 12, 32'h3), ent(4, S_NOT_EXECUTED, 0, RWMM_NONE, 11, 32'h4),
        idle("slot0_blocks_slot1", 5));
    add(ent(4, S_EXECUTED, 0, RWMM_NONE, 11, 32'h4), ent(3, S_EXECUTED, 0, RWMM_STORE, 12, 32'h3),
        ex("store_in_slot1", 2'b01, 2'b01, 4, 11, 0, 32'h4, 0, 9, 0));
    add(ent(2, S_EXECUTED, 0, RWMM_NONE, 13, 32'h2), ent(3, S_EXECUTED, 0, RWMM_NONE, 12, 32'h3),
        ex("swapped_index", 2'b11, 2'b11, 2, 12, 13, 32'h3, 32'h2, 2, 9));
    add(ent(1, S_NOT_USED, 0, RWMM_NONE, 14, 32'h1), ent(0, S_NOT_USED, 0, RWMM_NONE, 15, 32'h0),
        idle("unused_no_hit", 2));
    add(ent(1, S_EXECUTED, 0, RWMM_NONE, 14, 32'h1), ent(0, S_NOT_EXECUTED, 0, RWMM_NONE, 15, 32'h0),
        ex("to_tag1", 2'b01, 2'b01, 1, 14, 0, 32'h1, 0, 9, 0));
    add(ent(0, S_EXECUTED, 0, RWMM_NONE, 15, 32'h100), ent(15, S_EXECUTED, 0, RWMM_NONE, 16, 32'h115),
        ex("wrap", 2'b11, 2'b11, 15, 15, 16, 32'h100, 32'h115, 9, 2));

    do_reset("reset");
    foreach (vq[i]) begin
      clear_entries();
      entries_all[9] = vq[i].a;
      entries_all[2] = vq[i].b;
      step(vq[i].e);
    end

    // mem_ack while idle has no effect.
    clear_entries();
    do_reset("reset2");
    mem_ack = 1'b1;
    step(idle("ack_idle", 0));
    mem_ack = 1'b0;

    // Store in slot 0: three request cycles, then ack frees it; tag 14 waits until after.
    entries_all[9] = ent(15, S_EXECUTED, 0, RWMM_STORE, 3, 32'h0, 32'h100, 32'h55);
    entries_all[2] = ent(14, S_EXECUTED, 0, RWMM_LOAD, 4, 32'hB);
    req_cycles = 0;
    step(ex("store_req", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h100, 32'h55));
    if (mem_req) req_cycles++;
    entries_all[9].a  = 32'hDEAD;
    entries_all[9].vk = 32'hBEEF;
    for (int i = 0; i < 2; i++) begin
      step(ex("store_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h100, 32'h55));
      if (mem_req) req_cycles++;
    end
    cmp("store_req_cycles", 32'(req_cycles), 32'd3);
    mem_ack = 1'b1;
    step(ex("store_ack", 2'b00, 2'b01, 15, 0, 0, 0, 0, 9, 0));
    mem_ack = 1'b0;
    entries_all[9] = '0;
    step(ex("after_store", 2'b01, 2'b01, 14, 4, 0, 32'hB, 0, 2, 0));

    // Reset in the middle of a store abandons it.
    clear_entries();
    do_reset("reset3");
    entries_all[9] = ent(15, S_EXECUTED, 0, RWMM_STORE, 3, 32'h0, 32'h200, 32'h66);
    step(ex("store2_req", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h200, 32'h66));
    step(ex("store2_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h200, 32'h66));
    reset = 1'b1;
    step(idle("reset_mid_store", 0));
    reset = 1'b0;
    clear_entries();
    step(idle("post_reset_idle", 0));
    cmp("post_reset_mem_addr", mem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
